// File: rtl/dram_arbiter_pkg.sv
// Shared types for the two-port DRAM arbiter: request/response structs, FSM state
// and the winner-selection helper.
package dram_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam bit DATA_PRIO_DEFAULT = 1'b0;

  typedef struct packed {
    logic              mem_valid;
    logic              mem_instr;
    logic              mem_mode;   // 1 = write
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic              mem_ready;
    logic              mem_error;
    logic [DATA_W-1:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} arb_state_t;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} arb_port_t;

  // A tie goes to data under fixed priority, otherwise to the port that did not win last.
  function automatic arb_port_t pick_winner(input logic pend_i, input logic pend_d,
                                            input logic data_prio, input arb_port_t rr_last);
    arb_port_t w;
    if (pend_i && pend_d) begin
      if (data_prio) begin
        w = PORT_D;
      end else if (rr_last == PORT_I) begin
        w = PORT_D;
      end else begin
        w = PORT_I;
      end
    end else if (pend_d) begin
      w = PORT_D;
    end else begin
      w = PORT_I;
    end
    return w;
  endfunction

endpackage

// File: rtl/dram_arbiter_chk.sv
// Protocol invariants of the arbiter outputs; simulation only, no logic.
module dram_arbiter_chk (
  input logic clock,
  input logic reset,
  input logic imem_ready,
  input logic dmem_ready,
  input logic dram_valid
);

  a_one_owner: assert property (@(posedge clock) disable iff (!reset)
    !(imem_ready && dmem_ready));

  a_valid_pulse: assert property (@(posedge clock) disable iff (!reset)
    dram_valid |=> !dram_valid);

endmodule

// File: rtl/dram_arbiter_req_buf.sv
// Single-entry pending request register for one arbiter port. An incoming pulse is
// also visible combinationally so an idle arbiter can issue it on the next edge.
module arb_req_buf
  import dram_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  mem_in_type req,
  input  logic       clr,
  output logic       avail,
  output mem_in_type view,
  output logic       overrun
);

  logic       pend_r;
  mem_in_type entry_r;
  logic       overrun_r;

  // Capture only into an empty entry; a pulse on a full entry is dropped and flagged
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_r    <= 1'b0;
      entry_r   <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (clr) begin
        pend_r <= 1'b0;
      end else if (req.mem_valid && !pend_r) begin
        pend_r  <= 1'b1;
        entry_r <= req;
      end
      if (req.mem_valid && pend_r) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Present the held entry, or the fresh request when nothing is held
  always_comb begin
    avail = pend_r | req.mem_valid;
    if (pend_r) begin
      view = entry_r;
    end else begin
      view = req;
    end
  end

  assign overrun = overrun_r;

endmodule

// File: rtl/dram_arbiter.sv
// Two-port to one-port DRAM request arbiter: one transaction in flight, responses
// routed back to the issuing port, round-robin or fixed data priority on ties.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = DATA_PRIO_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  dram_in,
  input  mem_out_type dram_out
);

  arb_state_t  state_r, state_s;
  arb_port_t   owner_r, owner_s;
  arb_port_t   rr_last_r, rr_last_s;
  arb_port_t   winner_s;
  mem_in_type  dram_in_r, dram_in_s;
  mem_out_type imem_out_r, imem_out_s;
  mem_out_type dmem_out_r, dmem_out_s;
  logic        clr_i_s, clr_d_s;
  logic        avail_i_s, avail_d_s;
  mem_in_type  view_i_s, view_d_s;
  logic        err_overrun_i_s, err_overrun_d_s;
  logic        err_stray_r;

  arb_req_buf u_buf_i (
    .clock   (clock),
    .reset   (reset),
    .req     (imem_in),
    .clr     (clr_i_s),
    .avail   (avail_i_s),
    .view    (view_i_s),
    .overrun (err_overrun_i_s)
  );

  arb_req_buf u_buf_d (
    .clock   (clock),
    .reset   (reset),
    .req     (dmem_in),
    .clr     (clr_d_s),
    .avail   (avail_d_s),
    .view    (view_d_s),
    .overrun (err_overrun_d_s)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_s              = state_r;
    owner_s              = owner_r;
    rr_last_s            = rr_last_r;
    dram_in_s            = dram_in_r;
    dram_in_s.mem_valid  = 1'b0;
    imem_out_s           = imem_out_r;
    imem_out_s.mem_ready = 1'b0;
    dmem_out_s           = dmem_out_r;
    dmem_out_s.mem_ready = 1'b0;
    clr_i_s              = 1'b0;
    clr_d_s              = 1'b0;
    winner_s             = pick_winner(avail_i_s, avail_d_s, DATA_PRIO, rr_last_r);
    case (state_r)
      IDLE: begin
        if (avail_i_s || avail_d_s) begin
          if (winner_s == PORT_D) begin
            dram_in_s = view_d_s;
          end else begin
            dram_in_s = view_i_s;
          end
          dram_in_s.mem_valid = 1'b1;
          owner_s             = winner_s;
          rr_last_s           = winner_s;
          state_s             = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (dram_out.mem_ready) begin
          if (owner_r == PORT_D) begin
            dmem_out_s = dram_out;
            clr_d_s    = 1'b1;
          end else begin
            imem_out_s = dram_out;
            clr_i_s    = 1'b1;
          end
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; a downstream response outside WAIT is a sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      owner_r     <= PORT_I;
      rr_last_r   <= PORT_I;
      dram_in_r   <= '0;
      imem_out_r  <= '0;
      dmem_out_r  <= '0;
      err_stray_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      rr_last_r  <= rr_last_s;
      dram_in_r  <= dram_in_s;
      imem_out_r <= imem_out_s;
      dmem_out_r <= dmem_out_s;
      if (dram_out.mem_ready && (state_r != WAIT)) begin
        err_stray_r <= 1'b1;
      end
    end
  end

  assign dram_in  = dram_in_r;
  assign imem_out = imem_out_r;
  assign dmem_out = dmem_out_r;

  dram_arbiter_chk u_chk (
    .clock      (clock),
    .reset      (reset),
    .imem_ready (imem_out_r.mem_ready),
    .dmem_ready (dmem_out_r.mem_ready),
    .dram_valid (dram_in_r.mem_valid)
  );

endmodule

// File: tb/tb_dram_arbiter.sv
// Scenario bench for dram_arbiter: round-robin instance and fixed-data-priority
// instance share stimulus; expected issues/responses flow through queues.
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mode;
  } exp_issue_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_resp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  mem_in_type  imem_in, dmem_in, dram_in0, dram_in1, dram_in_v;
  mem_out_type dram_out, imem_out0, dmem_out0, imem_out1, dmem_out1, imem_out_v, dmem_out_v;
  exp_issue_t  issue_q[$];
  exp_resp_t   resp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clock = ~clock;

  dram_arbiter #(.DATA_PRIO(1'b0)) dut0 (
    .clock(clock), .reset(reset), .imem_in(imem_in), .imem_out(imem_out0),
    .dmem_in(dmem_in), .dmem_out(dmem_out0), .dram_in(dram_in0), .dram_out(dram_out));

  dram_arbiter #(.DATA_PRIO(1'b1)) dut1 (
    .clock(clock), .reset(reset), .imem_in(imem_in), .imem_out(imem_out1),
    .dmem_in(dmem_in), .dmem_out(dmem_out1), .dram_in(dram_in1), .dram_out(dram_out));

  assign dram_in_v  = sel ? dram_in1  : dram_in0;
  assign imem_out_v = sel ? imem_out1 : imem_out0;
  assign dmem_out_v = sel ? dmem_out1 : dmem_out0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    imem_in = '0;
    dmem_in = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_reqs();
    dram_out = '0;
    issue_q.delete();
    resp_q.delete();
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic set_req(input logic port, input logic [31:0] addr, input logic mode,
                         input logic [31:0] wdata, input bit expect_issue);
    mem_in_type r;
    r.mem_valid = 1'b1;
    r.mem_instr = ~port;
    r.mem_mode  = mode;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = mode ? 4'hF : 4'h0;
    if (port) dmem_in = r;
    else imem_in = r;
    if (expect_issue) issue_q.push_back('{port: port, addr: addr, wdata: wdata, mode: mode});
  endtask

  task automatic wait_issue(input int max, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles <= max) begin
      if (dram_in_v.mem_valid) found = 1'b1;
      else begin
        step();
        cycles++;
      end
    end
  endtask

  task automatic respond(input int delay, input logic port, input logic [31:0] rdata,
                         input logic err, output mem_out_type got, output mem_out_type other);
    resp_q.push_back('{port: port, rdata: rdata, err: err});
    repeat (delay) step();
    dram_out.mem_ready = 1'b1;
    dram_out.mem_error = err;
    dram_out.mem_rdata = rdata;
    step();
    dram_out = '0;
    got   = port ? dmem_out_v : imem_out_v;
    other = port ? imem_out_v : dmem_out_v;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({dram_in0, imem_out0, dmem_out0, dram_in1, imem_out1, dmem_out1} !== '0)
      $display("FAIL reset_outputs: got dram_valid=%0b imem_ready=%0b dmem_ready=%0b, required all zero",
               dram_in0.mem_valid, imem_out0.mem_ready, dmem_out0.mem_ready);
    else pass_cnt++;
    total_cnt++;
    if ({dut0.err_stray_r, dut0.err_overrun_i_s, dut0.err_overrun_d_s} !== 3'b000)
      $display("FAIL reset_flags: got %b required 000",
               {dut0.err_stray_r, dut0.err_overrun_i_s, dut0.err_overrun_d_s});
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    exp_issue_t e; exp_resp_t r; bit found; int cyc; mem_out_type got, other;
    apply_reset();
    sel = 1'b0;
    set_req(1'b0, 32'h0000_1000, 1'b0, 32'h0, 1'b1);
    step();
    clear_reqs();
    wait_issue(8, found, cyc);
    e = issue_q.pop_front();
    total_cnt++;
    if ({found, cyc, dram_in_v.mem_addr, dram_in_v.mem_mode} !== {1'b1, 32'd0, e.addr, e.mode})
      $display("FAIL single_issue: got found=%0b lat=%0d addr=%h required lat=0 addr=%h",
               found, cyc, dram_in_v.mem_addr, e.addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (dram_in_v.mem_valid !== 1'b0)
      $display("FAIL single_valid_pulse: got valid=%0b required 0", dram_in_v.mem_valid);
    else pass_cnt++;
    respond(4, 1'b0, 32'hDEAD_BEEF, 1'b0, got, other);
    r = resp_q.pop_front();
    total_cnt++;
    if ({got.mem_ready, got.mem_error, got.mem_rdata, other.mem_ready} !== {1'b1, r.err, r.rdata, 1'b0})
      $display("FAIL single_resp: got ready=%0b rdata=%h dmem_ready=%0b required 1 %h 0",
               got.mem_ready, got.mem_rdata, other.mem_ready, r.rdata);
    else pass_cnt++;
    step();
    total_cnt++;
    if (imem_out_v.mem_ready !== 1'b0)
      $display("FAIL single_ready_pulse: got ready=%0b required 0", imem_out_v.mem_ready);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    exp_issue_t e; exp_resp_t r; bit found; int cyc; mem_out_type got, other;
    apply_reset();
    sel = 1'b0;
    set_req(1'b1, 32'h0000_0200, 1'b1, 32'h1234_5678, 1'b1);
    set_req(1'b0, 32'h0000_0100, 1'b0, 32'h0, 1'b1);
    step();
    clear_reqs();
    for (int k = 0; k < 2; k++) begin
      wait_issue(8, found, cyc);
      e = issue_q.pop_front();
      total_cnt++;
      if ({found, dram_in_v.mem_addr, dram_in_v.mem_wdata, dram_in_v.mem_mode, dram_in_v.mem_wstrb}
          !== {1'b1, e.addr, e.wdata, e.mode, (e.mode ? 4'hF : 4'h0)})
        $display("FAIL simul_issue%0d: got found=%0b addr=%h wdata=%h required addr=%h wdata=%h",
                 k, found, dram_in_v.mem_addr, dram_in_v.mem_wdata, e.addr, e.wdata);
      else pass_cnt++;
      if (k == 1) begin
        total_cnt++;
        if (cyc !== 2)
          $display("FAIL simul_gap: got %0d idle cycles after RESP required 2", cyc);
        else pass_cnt++;
      end
      respond(2, e.port, 32'hA000_0000 + k, 1'b0, got, other);
      r = resp_q.pop_front();
      total_cnt++;
      if ({got.mem_ready, got.mem_error, got.mem_rdata, other.mem_ready} !== {1'b1, r.err, r.rdata, 1'b0})
        $display("FAIL simul_resp%0d: got ready=%0b rdata=%h other_ready=%0b required 1 %h 0",
                 k, got.mem_ready, got.mem_rdata, other.mem_ready, r.rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_round_robin();
    exp_issue_t e; exp_resp_t r; bit found; int cyc; mem_out_type got, other;
    int next_i, next_d;
    apply_reset();
    sel = 1'b0;
    set_req(1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b1);
    set_req(1'b0, 32'h0000_1000, 1'b0, 32'h0, 1'b1);
    next_i = 1;
    next_d = 1;
    step();
    clear_reqs();
    for (int i = 0; i < 8; i++) begin
      wait_issue(8, found, cyc);
      e = issue_q.pop_front();
      total_cnt++;
      if ({found, dram_in_v.mem_addr} !== {1'b1, e.addr})
        $display("FAIL rr_issue%0d: got found=%0b addr=%h required addr=%h", i, found, dram_in_v.mem_addr, e.addr);
      else pass_cnt++;
      respond(1, e.port, $urandom, 1'b0, got, other);
      r = resp_q.pop_front();
      total_cnt++;
      if ({got.mem_ready, got.mem_rdata, other.mem_ready} !== {1'b1, r.rdata, 1'b0})
        $display("FAIL rr_resp%0d: got ready=%0b rdata=%h other_ready=%0b required 1 %h 0",
                 i, got.mem_ready, got.mem_rdata, other.mem_ready, r.rdata);
      else pass_cnt++;
      if (i < 6) begin
        if (e.port) begin
          set_req(1'b1, 32'h0000_2000 + next_d, 1'b0, 32'h0, 1'b1);
          next_d++;
        end else begin
          set_req(1'b0, 32'h0000_1000 + next_i, 1'b0, 32'h0, 1'b1);
          next_i++;
        end
        step();
        clear_reqs();
      end
    end
  endtask

  task automatic test_data_prio();
    exp_issue_t e; exp_resp_t r; bit found; int cyc; mem_out_type got, other;
    apply_reset();
    sel = 1'b1;
    set_req(1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0);
    set_req(1'b0, 32'h0000_3100, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) issue_q.push_back('{port: 1'b1, addr: 32'h3000 + k, wdata: 32'h0, mode: 1'b0});
    issue_q.push_back('{port: 1'b0, addr: 32'h3100, wdata: 32'h0, mode: 1'b0});
    step();
    clear_reqs();
    for (int k = 0; k < 4; k++) begin
      wait_issue(8, found, cyc);
      e = issue_q.pop_front();
      total_cnt++;
      if ({found, dram_in_v.mem_addr} !== {1'b1, e.addr})
        $display("FAIL prio_issue%0d: got found=%0b addr=%h required addr=%h", k, found, dram_in_v.mem_addr, e.addr);
      else pass_cnt++;
      respond(1, e.port, 32'hB000_0000 + k, 1'b0, got, other);
      r = resp_q.pop_front();
      total_cnt++;
      if ({got.mem_ready, got.mem_rdata, other.mem_ready} !== {1'b1, r.rdata, 1'b0})
        $display("FAIL prio_resp%0d: got ready=%0b rdata=%h other_ready=%0b required 1 %h 0",
                 k, got.mem_ready, got.mem_rdata, other.mem_ready, r.rdata);
      else pass_cnt++;
      if (k < 2) begin
        set_req(1'b1, 32'h0000_3001 + k, 1'b0, 32'h0, 1'b0);
        step();
        clear_reqs();
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_error();
    exp_issue_t e; exp_resp_t r; bit found; int cyc; mem_out_type got, other;
    apply_reset();
    sel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_req(k == 0, 32'h0000_0300 + 4 * k, 1'b0, 32'h0, 1'b1);
      step();
      clear_reqs();
      wait_issue(8, found, cyc);
      e = issue_q.pop_front();
      total_cnt++;
      if ({found, dram_in_v.mem_addr} !== {1'b1, e.addr})
        $display("FAIL err_issue%0d: got found=%0b addr=%h required addr=%h", k, found, dram_in_v.mem_addr, e.addr);
      else pass_cnt++;
      respond(2, e.port, 32'h0BAD_0BAD + k, k == 0, got, other);
      r = resp_q.pop_front();
      total_cnt++;
      if ({got.mem_ready, got.mem_error, got.mem_rdata, other.mem_ready} !== {1'b1, r.err, r.rdata, 1'b0})
        $display("FAIL err_resp%0d: got ready=%0b error=%0b rdata=%h required 1 %0b %h",
                 k, got.mem_ready, got.mem_error, got.mem_rdata, r.err, r.rdata);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_overrun();
    exp_issue_t e; exp_resp_t r; bit found; int cyc; mem_out_type got, other;
    apply_reset();
    sel = 1'b0;
    set_req(1'b1, 32'h0000_0600, 1'b0, 32'h0, 1'b1);
    set_req(1'b0, 32'h0000_0400, 1'b0, 32'h0, 1'b1);
    step();
    clear_reqs();
    for (int k = 0; k < 2; k++) begin
      wait_issue(8, found, cyc);
      e = issue_q.pop_front();
      total_cnt++;
      if ({found, dram_in_v.mem_addr} !== {1'b1, e.addr})
        $display("FAIL ovr_issue%0d: got found=%0b addr=%h required addr=%h", k, found, dram_in_v.mem_addr, e.addr);
      else pass_cnt++;
      if (k == 0) begin
        set_req(1'b0, 32'h0000_0500, 1'b0, 32'h0, 1'b0);
        step();
        clear_reqs();
        total_cnt++;
        if ({dut0.err_overrun_i_s, dut0.err_overrun_d_s} !== 2'b10)
          $display("FAIL ovr_flag: got i=%0b d=%0b required i=1 d=0", dut0.err_overrun_i_s, dut0.err_overrun_d_s);
        else pass_cnt++;
      end
      respond(2, e.port, 32'hC000_0000 + k, 1'b0, got, other);
      r = resp_q.pop_front();
      total_cnt++;
      if ({got.mem_ready, got.mem_rdata, other.mem_ready} !== {1'b1, r.rdata, 1'b0})
        $display("FAIL ovr_resp%0d: got ready=%0b rdata=%h required 1 %h", k, got.mem_ready, got.mem_rdata, r.rdata);
      else pass_cnt++;
    end
    wait_issue(6, found, cyc);
    total_cnt++;
    if (found !== 1'b0)
      $display("FAIL ovr_dropped: got extra issue addr=%h required none", dram_in_v.mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    exp_issue_t e; exp_resp_t r; bit found; int cyc; mem_out_type got, other;
    apply_reset();
    sel = 1'b0;
    set_req(1'b0, 32'h0000_0700, 1'b0, 32'h0, 1'b1);
    step();
    clear_reqs();
    wait_issue(8, found, cyc);
    e = issue_q.pop_front();
    step();
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({found, dut0.state_r} !== {1'b1, IDLE})
      $display("FAIL rst_async: got found=%0b state=%0d required 1 IDLE", found, dut0.state_r);
    else pass_cnt++;
    step();
    reset = 1'b1;
    step();
    dram_out.mem_ready = 1'b1;
    dram_out.mem_rdata = 32'h0000_0077;
    step();
    dram_out = '0;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if ({imem_out_v.mem_ready, dmem_out_v.mem_ready, dram_in_v.mem_valid, dut0.err_stray_r} !== 4'b0001)
        $display("FAIL rst_stray%0d: got iready=%0b dready=%0b valid=%0b stray=%0b required 0 0 0 1", k,
                 imem_out_v.mem_ready, dmem_out_v.mem_ready, dram_in_v.mem_valid, dut0.err_stray_r);
      else pass_cnt++;
      step();
    end
    set_req(1'b0, 32'h0000_0704, 1'b0, 32'h0, 1'b1);
    step();
    clear_reqs();
    wait_issue(8, found, cyc);
    e = issue_q.pop_front();
    total_cnt++;
    if ({found, dram_in_v.mem_addr} !== {1'b1, e.addr})
      $display("FAIL rst_next_issue: got found=%0b addr=%h required addr=%h", found, dram_in_v.mem_addr, e.addr);
    else pass_cnt++;
    respond(1, e.port, 32'h0000_0099, 1'b0, got, other);
    r = resp_q.pop_front();
    total_cnt++;
    if ({got.mem_ready, got.mem_rdata, other.mem_ready} !== {1'b1, r.rdata, 1'b0})
      $display("FAIL rst_next_resp: got ready=%0b rdata=%h required 1 %h", got.mem_ready, got.mem_rdata, r.rdata);
    else pass_cnt++;
  endtask

  initial begin
    reset    = 1'b0;
    sel      = 1'b0;
    imem_in  = '0;
    dmem_in  = '0;
    dram_out = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_data_prio();
    test_error();
    test_overrun();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
